id_exe_reg: RTL and testbench
=============================

ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 Parameter DATA_W, 32, width of PC and register-operand fields.
REQ-002 Parameter CNT_W, 16, width of stall/flush event counters.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 freeze  in  1  hazard stall; hold all registered contents.
REQ-006 flush  in  1  branch taken in EXE; replace next contents with bubble.
REQ-007 valid_in  in  1  ID stage presents a real instruction.
REQ-008 pc_in  in  DATA_W  PC+4 of the decoded instruction.
REQ-009 exe_cmd_in  in  4  ALU command from the control unit.
REQ-010 mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in  in  1 each  control bits from the control unit.
REQ-011 val_rn_in, val_rm_in  in  DATA_W each  register-file read values.
REQ-012 imm_in  in  1  immediate-operand flag; shift_operand_in  in  12; signed_imm_24_in  in  24.
REQ-013 dest_in  in  4  writeback register; src1_in, src2_in  in  4 each  source registers for forwarding.
REQ-014 status_in  in  4  current NZCV flags.
REQ-015 One registered output per input above, suffix _out, same width; valid_out  out  1.
REQ-016 stall_cnt  out  CNT_W  cycles with freeze applied; flush_cnt  out  CNT_W  bubbles inserted by flush.

Function
REQ-017 Per rising edge, priority: flush > freeze > load.
REQ-018 Load (flush=0, freeze=0): every _out takes its _in value; valid_out takes valid_in; latency exactly one cycle.
REQ-019 Flush: valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out cleared to 0; exe_cmd_out set to EXE_NOP (4'b0000); data fields cleared to 0.
REQ-020 Flush while freeze=1: flush wins; bubble inserted, stall_cnt not incremented.
REQ-021 Freeze (flush=0): all _out and valid_out hold previous values.
REQ-022 stall_cnt increments by 1 on each edge where freeze=1 and flush=0; saturates at 2^CNT_W-1, no wrap.
REQ-023 flush_cnt increments by 1 on each edge where flush=1 and the register held valid_out=1 or valid_in=1; saturates, no wrap.
REQ-024 valid_in=0 on load: control bits loaded as presented but valid_out=0; writes/memory enables shall be gated to 0 (bubble), data fields still loaded.
REQ-025 Outputs are registered only; no combinational path from any input to any output.
REQ-026 No X propagation: every output driven to a known value every cycle after reset.

Reset
REQ-027 rst_n low asynchronously clears all _out, valid_out, stall_cnt, flush_cnt to 0 (exe_cmd_out = EXE_NOP) without a clock edge.
REQ-028 Reset asserted mid-freeze or mid-flush overrides both; first edge after rst_n rises behaves as a normal load.

Structure
REQ-029 Shared package arm_pkg holds EXE_CMD_W=4, EXE_NOP, exe_cmd encodings (MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000) and REG_ADDR_W=4.
REQ-030 One sub-module sat_counter (parameter CNT_W; ports clk, rst_n, inc, count) instantiated twice for the counters.

Verification
REQ-031 Load: valid_in=1, exe_cmd_in=0010, wb_en_in=1, dest_in=4'd5, val_rn_in=32'h10 -> next edge: exe_cmd_out=0010, wb_en_out=1, dest_out=5, val_rn_out=32'h10, valid_out=1.
REQ-032 Freeze 3 cycles with inputs changing -> outputs unchanged across all 3 edges; stall_cnt=3.
REQ-033 Flush with freeze=1 and valid_out=1 -> next edge: valid_out=0, wb_en_out=0, mem_w_en_out=0, exe_cmd_out=0000; flush_cnt=1, stall_cnt unchanged.
REQ-034 Saturation: CNT_W=4, freeze held 20 cycles -> stall_cnt=15, no wrap to 0.
REQ-035 valid_in=0 with mem_w_en_in=1, wb_en_in=1 -> valid_out=0, mem_w_en_out=0, wb_en_out=0.
REQ-036 rst_n pulled low between edges while freeze=1 -> all outputs 0 immediately; after release, next edge loads inputs.

Source files
------------

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ALU command encodings and pipeline helpers
package arm_pkg;

  localparam int EXE_CMD_W  = 4;
  localparam int REG_ADDR_W = 4;

  typedef enum logic [EXE_CMD_W-1:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

  // Side-effecting enables that must never fire for a bubble
  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
  } enables_t;

  function automatic enables_t gate_enables(enables_t e, logic valid);
    return e & {3{valid}};
  endfunction

endpackage

// File: rtl/id_exe_reg_if.sv
// rtl/id_exe_reg_if.sv - ID-to-EXE pipeline register bus
interface id_exe_reg_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  import arm_pkg::*;

  logic                   freeze;
  logic                   flush;
  logic                   valid_in;
  logic [DATA_W-1:0]      pc_in;
  logic [EXE_CMD_W-1:0]   exe_cmd_in;
  logic                   mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in;
  logic [DATA_W-1:0]      val_rn_in, val_rm_in;
  logic                   imm_in;
  logic [11:0]            shift_operand_in;
  logic [23:0]            signed_imm_24_in;
  logic [REG_ADDR_W-1:0]  dest_in, src1_in, src2_in;
  logic [3:0]             status_in;

  logic                   valid_out;
  logic [DATA_W-1:0]      pc_out;
  logic [EXE_CMD_W-1:0]   exe_cmd_out;
  logic                   mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out;
  logic [DATA_W-1:0]      val_rn_out, val_rm_out;
  logic                   imm_out;
  logic [11:0]            shift_operand_out;
  logic [23:0]            signed_imm_24_out;
  logic [REG_ADDR_W-1:0]  dest_out, src1_out, src2_out;
  logic [3:0]             status_out;
  logic [CNT_W-1:0]       stall_cnt, flush_cnt;

  modport master (
    output freeze, flush, valid_in, pc_in, exe_cmd_in, mem_r_en_in, mem_w_en_in,
           wb_en_in, b_in, s_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
           signed_imm_24_in, dest_in, src1_in, src2_in, status_in,
    input  valid_out, pc_out, exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out,
           b_out, s_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
           signed_imm_24_out, dest_out, src1_out, src2_out, status_out,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  freeze, flush, valid_in, pc_in, exe_cmd_in, mem_r_en_in, mem_w_en_in,
           wb_en_in, b_in, s_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
           signed_imm_24_in, dest_in, src1_in, src2_in, status_in,
    output valid_out, pc_out, exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out,
           b_out, s_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
           signed_imm_24_out, dest_out, src1_out, src2_out, status_out,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count events, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/id_exe_reg.sv
// rtl/id_exe_reg.sv - ID/EXE pipeline register with freeze, flush and event counters
module id_exe_reg
  import arm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst_n,
  id_exe_reg_if.slave bus
);

  localparam logic [DATA_W-1:0] ZERO_DATA = '0;

  enables_t en_in;
  enables_t en_gated;
  logic     stall_inc;
  logic     flush_inc;

  assign en_in    = '{wb_en: bus.wb_en_in, mem_r_en: bus.mem_r_en_in, mem_w_en: bus.mem_w_en_in};
  assign en_gated = gate_enables(en_in, bus.valid_in);

  // A flush overrides freeze, so a frozen-and-flushed edge is not a stall
  assign stall_inc = bus.freeze & ~bus.flush;
  // Only count flushes that actually squash an instruction
  assign flush_inc = bus.flush & (bus.valid_out | bus.valid_in);

  // Pipeline register: flush inserts a bubble, freeze holds, otherwise load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.flush) begin
      bus.valid_out         <= 1'b0;
      bus.pc_out            <= ZERO_DATA;
      bus.exe_cmd_out       <= EXE_NOP;
      bus.mem_r_en_out      <= 1'b0;
      bus.mem_w_en_out      <= 1'b0;
      bus.wb_en_out         <= 1'b0;
      bus.b_out             <= 1'b0;
      bus.s_out             <= 1'b0;
      bus.val_rn_out        <= ZERO_DATA;
      bus.val_rm_out        <= ZERO_DATA;
      bus.imm_out           <= 1'b0;
      bus.shift_operand_out <= '0;
      bus.signed_imm_24_out <= '0;
      bus.dest_out          <= '0;
      bus.src1_out          <= '0;
      bus.src2_out          <= '0;
      bus.status_out        <= '0;
    end else if (!bus.freeze) begin
      bus.valid_out         <= bus.valid_in;
      bus.pc_out            <= bus.pc_in;
      bus.exe_cmd_out       <= bus.exe_cmd_in;
      bus.mem_r_en_out      <= en_gated.mem_r_en;
      bus.mem_w_en_out      <= en_gated.mem_w_en;
      bus.wb_en_out         <= en_gated.wb_en;
      bus.b_out             <= bus.b_in;
      bus.s_out             <= bus.s_in;
      bus.val_rn_out        <= bus.val_rn_in;
      bus.val_rm_out        <= bus.val_rm_in;
      bus.imm_out           <= bus.imm_in;
      bus.shift_operand_out <= bus.shift_operand_in;
      bus.signed_imm_24_out <= bus.signed_imm_24_in;
      bus.dest_out          <= bus.dest_in;
      bus.src1_out          <= bus.src1_in;
      bus.src2_out          <= bus.src2_in;
      bus.status_out        <= bus.status_in;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (bus.flush_cnt)
  );

endmodule

// File: tb/tb_id_exe_reg.sv
// tb/tb_id_exe_reg.sv - self-checking bench for id_exe_reg
module tb_id_exe_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  id_exe_reg_if #(.DATA_W(32), .CNT_W(16)) bus ();
  id_exe_reg_if #(.DATA_W(32), .CNT_W(4))  bus4 ();

  id_exe_reg #(.DATA_W(32), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  id_exe_reg #(.DATA_W(32), .CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  // Narrow-counter instance sees identical stimulus
  assign bus4.freeze           = bus.freeze;
  assign bus4.flush            = bus.flush;
  assign bus4.valid_in         = bus.valid_in;
  assign bus4.pc_in            = bus.pc_in;
  assign bus4.exe_cmd_in       = bus.exe_cmd_in;
  assign bus4.mem_r_en_in      = bus.mem_r_en_in;
  assign bus4.mem_w_en_in      = bus.mem_w_en_in;
  assign bus4.wb_en_in         = bus.wb_en_in;
  assign bus4.b_in             = bus.b_in;
  assign bus4.s_in             = bus.s_in;
  assign bus4.val_rn_in        = bus.val_rn_in;
  assign bus4.val_rm_in        = bus.val_rm_in;
  assign bus4.imm_in           = bus.imm_in;
  assign bus4.shift_operand_in = bus.shift_operand_in;
  assign bus4.signed_imm_24_in = bus.signed_imm_24_in;
  assign bus4.dest_in          = bus.dest_in;
  assign bus4.src1_in          = bus.src1_in;
  assign bus4.src2_in          = bus.src2_in;
  assign bus4.status_in        = bus.status_in;

  // Expected architectural contents of the register
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  cmd;
    logic        mr, mw, wb, b, s;
    logic [31:0] rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] si;
    logic [3:0]  dest, src1, src2, status;
  } exp_t;

  exp_t exp_r;
  int   exp_stall, exp_flush, exp_stall4;

  typedef struct {
    logic        frz, fl, vin;
    logic [3:0]  cmd;
    logic        wb, mw;
    logic [3:0]  dest;
    logic [31:0] rn;
    logic        e_v;
    logic [3:0]  e_cmd;
    logic        e_wb, e_mw;
    logic [3:0]  e_dest;
    logic [31:0] e_rn;
    int          e_st, e_fl;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int sat_inc(int v, int max);
    return (v >= max) ? max : v + 1;
  endfunction

  task automatic zero_inputs();
    bus.freeze = 0; bus.flush = 0; bus.valid_in = 0; bus.pc_in = 0; bus.exe_cmd_in = 0;
    bus.mem_r_en_in = 0; bus.mem_w_en_in = 0; bus.wb_en_in = 0; bus.b_in = 0; bus.s_in = 0;
    bus.val_rn_in = 0; bus.val_rm_in = 0; bus.imm_in = 0; bus.shift_operand_in = 0;
    bus.signed_imm_24_in = 0; bus.dest_in = 0; bus.src1_in = 0; bus.src2_in = 0; bus.status_in = 0;
  endtask

  task automatic rand_inputs();
    bus.freeze = ($urandom_range(0, 3) == 0);
    bus.flush = ($urandom_range(0, 6) == 0);
    bus.valid_in = ($urandom_range(0, 3) != 0);
    bus.pc_in = $urandom; bus.exe_cmd_in = 4'($urandom_range(0, 9));
    bus.mem_r_en_in = 1'($urandom); bus.mem_w_en_in = 1'($urandom); bus.wb_en_in = 1'($urandom);
    bus.b_in = 1'($urandom); bus.s_in = 1'($urandom);
    bus.val_rn_in = $urandom; bus.val_rm_in = $urandom; bus.imm_in = 1'($urandom);
    bus.shift_operand_in = 12'($urandom); bus.signed_imm_24_in = 24'($urandom);
    bus.dest_in = 4'($urandom); bus.src1_in = 4'($urandom); bus.src2_in = 4'($urandom);
    bus.status_in = 4'($urandom);
  endtask

  // What one rising edge should do, stated directly from the stage rules
  task automatic model_edge();
    if (bus.flush) begin
      if (exp_r.valid || bus.valid_in) exp_flush = sat_inc(exp_flush, 65535);
      exp_r = '0;
    end else if (bus.freeze) begin
      exp_stall  = sat_inc(exp_stall, 65535);
      exp_stall4 = sat_inc(exp_stall4, 15);
    end else begin
      exp_r.valid = bus.valid_in;      exp_r.pc = bus.pc_in;           exp_r.cmd = bus.exe_cmd_in;
      exp_r.mr = bus.mem_r_en_in && bus.valid_in;
      exp_r.mw = bus.mem_w_en_in && bus.valid_in;
      exp_r.wb = bus.wb_en_in && bus.valid_in;
      exp_r.b = bus.b_in;              exp_r.s = bus.s_in;
      exp_r.rn = bus.val_rn_in;        exp_r.rm = bus.val_rm_in;       exp_r.imm = bus.imm_in;
      exp_r.sh = bus.shift_operand_in; exp_r.si = bus.signed_imm_24_in;
      exp_r.dest = bus.dest_in;        exp_r.src1 = bus.src1_in;       exp_r.src2 = bus.src2_in;
      exp_r.status = bus.status_in;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".valid_out"}, 64'(bus.valid_out), 64'(exp_r.valid));
    chk({tag, ".pc_out"}, 64'(bus.pc_out), 64'(exp_r.pc));
    chk({tag, ".exe_cmd_out"}, 64'(bus.exe_cmd_out), 64'(exp_r.cmd));
    chk({tag, ".mem_r_en_out"}, 64'(bus.mem_r_en_out), 64'(exp_r.mr));
    chk({tag, ".mem_w_en_out"}, 64'(bus.mem_w_en_out), 64'(exp_r.mw));
    chk({tag, ".wb_en_out"}, 64'(bus.wb_en_out), 64'(exp_r.wb));
    chk({tag, ".b_out"}, 64'(bus.b_out), 64'(exp_r.b));
    chk({tag, ".s_out"}, 64'(bus.s_out), 64'(exp_r.s));
    chk({tag, ".val_rn_out"}, 64'(bus.val_rn_out), 64'(exp_r.rn));
    chk({tag, ".val_rm_out"}, 64'(bus.val_rm_out), 64'(exp_r.rm));
    chk({tag, ".imm_out"}, 64'(bus.imm_out), 64'(exp_r.imm));
    chk({tag, ".shift_operand_out"}, 64'(bus.shift_operand_out), 64'(exp_r.sh));
    chk({tag, ".signed_imm_24_out"}, 64'(bus.signed_imm_24_out), 64'(exp_r.si));
    chk({tag, ".dest_out"}, 64'(bus.dest_out), 64'(exp_r.dest));
    chk({tag, ".src1_out"}, 64'(bus.src1_out), 64'(exp_r.src1));
    chk({tag, ".src2_out"}, 64'(bus.src2_out), 64'(exp_r.src2));
    chk({tag, ".status_out"}, 64'(bus.status_out), 64'(exp_r.status));
    chk({tag, ".stall_cnt"}, 64'(bus.stall_cnt), 64'(exp_stall));
    chk({tag, ".flush_cnt"}, 64'(bus.flush_cnt), 64'(exp_flush));
    chk({tag, ".stall_cnt4"}, 64'(bus4.stall_cnt), 64'(exp_stall4));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_r = '0; exp_stall = 0; exp_flush = 0; exp_stall4 = 0;
  endtask

  initial begin
    //          frz fl vin cmd   wb mw dest  rn            | v cmd   wb mw dest  rn           st fl
    vecs[0] = '{0, 0, 1, 4'h2, 1, 0, 4'd5,  32'h10,        1, 4'h2, 1, 0, 4'd5,  32'h10,       0, 0};
    vecs[1] = '{1, 0, 1, 4'h4, 0, 1, 4'd7,  32'h20,        1, 4'h2, 1, 0, 4'd5,  32'h10,       1, 0};
    vecs[2] = '{1, 0, 0, 4'h8, 1, 1, 4'd9,  32'h30,        1, 4'h2, 1, 0, 4'd5,  32'h10,       2, 0};
    vecs[3] = '{1, 0, 1, 4'h6, 0, 0, 4'd3,  32'h40,        1, 4'h2, 1, 0, 4'd5,  32'h10,       3, 0};
    vecs[4] = '{1, 1, 1, 4'h3, 1, 1, 4'd1,  32'h50,        0, 4'h0, 0, 0, 4'd0,  32'h0,        3, 1};
    vecs[5] = '{0, 0, 0, 4'h1, 1, 1, 4'd6,  32'h60,        0, 4'h1, 0, 0, 4'd6,  32'h60,       3, 1};
    vecs[6] = '{0, 1, 0, 4'h5, 1, 1, 4'd2,  32'h70,        0, 4'h0, 0, 0, 4'd0,  32'h0,        3, 1};
    vecs[7] = '{0, 0, 1, 4'h9, 0, 1, 4'd15, 32'hFFFF_FFFF, 1, 4'h9, 0, 1, 4'd15, 32'hFFFF_FFFF, 3, 1};
    vecs[8] = '{0, 1, 0, 4'h7, 1, 0, 4'd4,  32'h80,        0, 4'h0, 0, 0, 4'd0,  32'h0,        3, 2};

    zero_inputs();
    model_reset();
    #2;
    compare_all("reset");
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      bus.freeze = vecs[i].frz; bus.flush = vecs[i].fl; bus.valid_in = vecs[i].vin;
      bus.exe_cmd_in = vecs[i].cmd; bus.wb_en_in = vecs[i].wb; bus.mem_w_en_in = vecs[i].mw;
      bus.dest_in = vecs[i].dest; bus.val_rn_in = vecs[i].rn;
      tick();
      chk($sformatf("vec%0d.valid_out", i), 64'(bus.valid_out), 64'(vecs[i].e_v));
      chk($sformatf("vec%0d.exe_cmd_out", i), 64'(bus.exe_cmd_out), 64'(vecs[i].e_cmd));
      chk($sformatf("vec%0d.wb_en_out", i), 64'(bus.wb_en_out), 64'(vecs[i].e_wb));
      chk($sformatf("vec%0d.mem_w_en_out", i), 64'(bus.mem_w_en_out), 64'(vecs[i].e_mw));
      chk($sformatf("vec%0d.dest_out", i), 64'(bus.dest_out), 64'(vecs[i].e_dest));
      chk($sformatf("vec%0d.val_rn_out", i), 64'(bus.val_rn_out), 64'(vecs[i].e_rn));
      chk($sformatf("vec%0d.stall_cnt", i), 64'(bus.stall_cnt), 64'(vecs[i].e_st));
      chk($sformatf("vec%0d.flush_cnt", i), 64'(bus.flush_cnt), 64'(vecs[i].e_fl));
    end

    // Narrow counter saturation under a long freeze
    zero_inputs();
    bus.freeze = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.pc_in = $urandom;
      tick();
      compare_all("sat");
    end
    chk("sat.stall_cnt4_final", 64'(bus4.stall_cnt), 64'd15);

    // Asynchronous reset in the middle of a frozen cycle
    zero_inputs();
    bus.valid_in = 1; bus.wb_en_in = 1; bus.exe_cmd_in = 4'h7; bus.dest_in = 4'd9;
    bus.val_rn_in = 32'hDEAD_BEEF;
    tick();
    compare_all("pre_rst");
    bus.freeze = 1'b1;
    bus.pc_in = 32'h1234;
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    bus.freeze = 1'b0;
    bus.valid_in = 1; bus.exe_cmd_in = 4'h3; bus.dest_in = 4'd11; bus.val_rn_in = 32'h55;
    #1 rst_n = 1'b1;
    tick();
    compare_all("post_rst");
    chk("post_rst.dest_out", 64'(bus.dest_out), 64'd11);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      tick();
      compare_all($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
